mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined 16x16=16 multiplier among NUM_REQ requesters.
- Round-robin arbitration issues at most one multiply per cycle. The block tracks each requester ID through the fixed-latency multiplier pipeline and returns the result through a per-requester response register.
- Sits between compute-unit requesters and the DSP multiplier instance.
- Each requester may have at most one operation outstanding.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
LATENCY, 2, multiplier pipeline latency in cycles; must match the attached multiplier
ID_W, $clog2(NUM_REQ), width of the internal requester tag

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  per-requester grant; request accepted when valid&ready
req_in0  input  NUM_REQ*16  operand 0, requester i at bits [16*i+15:16*i]
req_in1  input  NUM_REQ*16  operand 1, same packing
rsp_valid  output  NUM_REQ  result available for requester i
rsp_ready  input  NUM_REQ  requester i consumes its result
rsp_data  output  NUM_REQ*16  result for requester i, same packing
mul_in0  output  16  to multiplier in0
mul_in1  output  16  to multiplier in1
mul_valid_in  output  1  to multiplier valid_in
mul_out  input  16  from multiplier out
mul_valid_out  input  1  from multiplier valid_out
idle  output  1  no busy requester and tag pipe empty
error  output  1  sticky: mul_valid_out disagrees with the tag pipeline

Behaviour:
- Reset (async assert, synchronous-to-clock deassert by integration) clears:
  - busy[] = 0
  - rsp_valid = 0
  - rsp_data = 0
  - tag pipe valid bits = 0
  - error = 0
  - rr pointer = NUM_REQ-1, so requester 0 has highest priority first
  - After reset, idle = 1, req_ready = 0, mul_valid_in = 0.
- Eligibility:
  - elig[i] = req_valid[i] & ~busy[i], where busy is registered.
  - busy[i] is set on request accept and cleared on the rsp handshake (rsp_valid[i] & rsp_ready[i]).
- Arbitration (combinational, per cycle):
  - Grant the first eligible index searching from rr+1 upward, modulo NUM_REQ.
  - req_ready is one-hot or zero; req_ready[g] = 1 only for the winner g. req_ready depends combinationally on req_valid.
  - On grant, rr <= g at the clock edge. With no grant, rr holds.
- Issue:
  - In the grant cycle T: mul_in0/mul_in1 = operands of g, mul_valid_in = 1.
  - With no grant: mul_in0 = mul_in1 = 0 and mul_valid_in = 0.
- Tag pipe:
  - LATENCY-stage shift register of {valid, id}. Stage 0 loads {grant_valid, g} at the edge ending cycle T.
  - The last stage is aligned with mul_out in cycle T+LATENCY.
- Writeback:
  - When the last tag stage is valid with id k, at the edge ending T+LATENCY: rsp_data[k] <= mul_out, rsp_valid[k] <= 1.
  - rsp_valid[k] is therefore first high in cycle T+LATENCY+1. Accept-to-response latency is LATENCY+1 cycles.
  - rsp_data[k] holds until the next writeback to k.
  - rsp_valid[k] clears on the edge after the rsp handshake.
- Arithmetic: the multiplier result is the low 16 bits of the unsigned product; the block passes it through unmodified.
- Throughput: one issue per cycle across all requesters. Per requester, the next grant comes no earlier than the cycle after its rsp handshake, because busy is registered. A same-cycle rsp handshake plus new request from the same requester is not granted that cycle.
- Overflow: no writeback can collide with a pending rsp_valid, because busy blocks reissue. No backpressure toward the multiplier is needed.
- Error check:
  - Sets error when mul_valid_out != last tag stage valid.
  - Masked for LATENCY cycles after reset deassertion, because multiplier valid registers are not reset.
  - error stays set until reset.
- idle = (busy == 0) & no valid tag stage.
- Reset mid-operation: in-flight products are dropped, no rsp_valid results, and busy is cleared.

Test Plan:
1. Single op: after reset, req_valid[0]=1, in0=0x0003, in1=0x0005 in cycle 0 -> req_ready[0]=1 and mul_valid_in=1 in cycle 0; rsp_valid[0]=1, rsp_data[0]=0x000F from cycle 3; with rsp_ready[0]=1 in cycle 3, rsp_valid[0]=0 in cycle 4 and idle=1.
2. Round robin: all four req_valid high, each with its own result held (rsp_ready=0) -> grants 0,1,2,3 in cycles 0..3 one-hot; no further grants while busy; rsp_valid bits rise in cycles 3,4,5,6.
3. Wrap product: in0=0xFFFF, in1=0x0002 on requester 2 -> rsp_data[2]=0xFFFE. Also in0=0x1234, in1=0x0100 -> 0x3400.
4. Busy block: requester 1 holds rsp_ready[1]=0 for 10 cycles with req_valid[1]=1 -> no second grant. Raise rsp_ready[1] in cycle k -> next grant to 1 in cycle k+1, never in cycle k.
5. Reset mid-flight: grant requester 3 in cycle 0, assert reset in cycle 1 -> rsp_valid=0 throughout; after release, no stale rsp_valid[3]; error stays 0.
6. Error detect: force mul_valid_out=1 with the tag pipe empty, outside the post-reset mask -> error=1 next cycle and sticky until reset.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one pipelined 16x16 multiplier among NUM_REQ requesters,
// tagging each issue with its requester ID so the product lands in that requester's response register.
module mul_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_in0,
    input  logic [NUM_REQ*16-1:0]   req_in1,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [NUM_REQ*16-1:0]   rsp_data,
    output logic [15:0]             mul_in0,
    output logic [15:0]             mul_in1,
    output logic                    mul_valid_in,
    input  logic [15:0]             mul_out,
    input  logic                    mul_valid_out,
    output logic                    idle,
    output logic                    error
);

    localparam int unsigned MASK_W = $clog2(LATENCY + 1);

    logic [NUM_REQ-1:0]    busy_q, busy_d;
    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    rsp_hs;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic                  gnt_v;
    logic [ID_W-1:0]       gnt_id;
    logic [31:0]           idx;

    logic [LATENCY-1:0]    tag_v_q, tag_v_d;
    logic [ID_W-1:0]       tag_id_q [LATENCY];
    logic [ID_W-1:0]       tag_id_d [LATENCY];
    logic                  tag_last_v;
    logic [ID_W-1:0]       tag_last_id;

    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*16-1:0] rsp_data_q, rsp_data_d;

    logic [MASK_W-1:0]     mask_q, mask_d;
    logic                  error_q, error_d;

    assign elig        = req_valid & ~busy_q;
    assign rsp_hs      = rsp_valid_q & rsp_ready;
    assign tag_last_v  = tag_v_q[LATENCY-1];
    assign tag_last_id = tag_id_q[LATENCY-1];

    // Search starts one past the last winner, so the previous winner has lowest priority.
    always_comb begin
        gnt_v     = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        req_ready = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(rr_q) + off) % NUM_REQ;
            if (!gnt_v && elig[idx[ID_W-1:0]]) begin
                gnt_v  = 1'b1;
                gnt_id = idx[ID_W-1:0];
            end
        end
        if (gnt_v) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        mul_valid_in = gnt_v;
        mul_in0      = '0;
        mul_in1      = '0;
        if (gnt_v) begin
            mul_in0 = req_in0[{gnt_id, 4'b0000} +: 16];
            mul_in1 = req_in1[{gnt_id, 4'b0000} +: 16];
        end
    end

    always_comb begin
        busy_d      = (busy_q | req_ready) & ~rsp_hs;
        rr_d        = gnt_v ? gnt_id : rr_q;

        tag_v_d     = '0;
        tag_v_d[0]  = gnt_v;
        tag_id_d[0] = gnt_id;
        for (int unsigned s = 1; s < LATENCY; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end

        // Busy keeps a requester from reissuing, so a writeback never meets a pending result.
        rsp_valid_d = rsp_valid_q & ~rsp_hs;
        rsp_data_d  = rsp_data_q;
        if (tag_last_v) begin
            rsp_valid_d[tag_last_id]                = 1'b1;
            rsp_data_d[{tag_last_id, 4'b0000} +: 16] = mul_out;
        end

        // Multiplier valid flops are not reset, so their output is ignored until they flush.
        mask_d  = (mask_q != '0) ? mask_q - 1'b1 : mask_q;
        error_d = error_q | ((mask_q == '0) && (mul_valid_out != tag_last_v));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            rr_q        <= ID_W'(NUM_REQ - 1);
            tag_v_q     <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            mask_q      <= MASK_W'(LATENCY);
            error_q     <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            rr_q        <= rr_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mask_q      <= mask_d;
            error_q     <= error_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign idle      = (busy_q == '0) && (tag_v_q == '0);
    assign error     = error_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized and directed bench for mul_share_arbiter, checked every cycle against a
// transaction-level model (busy flags, round-robin pointer, queue of in-flight products).
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_in0;
    logic [NUM_REQ*16-1:0] req_in1;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [NUM_REQ*16-1:0] rsp_data;
    logic [15:0]           mul_in0;
    logic [15:0]           mul_in1;
    logic                  mul_valid_in;
    logic [15:0]           mul_out;
    logic                  mul_valid_out;
    logic                  idle;
    logic                  error;
    logic                  force_err;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in0(req_in0), .req_in1(req_in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_valid_in(mul_valid_in),
        .mul_out(mul_out), .mul_valid_out(mul_valid_out),
        .idle(idle), .error(error)
    );

    // Stand-in for the DSP multiplier: fixed latency, valid flops never reset.
    logic [15:0] mp_d [LATENCY] = '{default: '0};
    logic        mp_v [LATENCY] = '{default: 1'b0};
    always @(posedge clock) begin
        mp_v[0] <= mul_valid_in;
        mp_d[0] <= mul_in0 * mul_in1;
        for (int s = 1; s < LATENCY; s++) begin
            mp_v[s] <= mp_v[s-1];
            mp_d[s] <= mp_d[s-1];
        end
    end
    assign mul_out       = mp_d[LATENCY-1];
    assign mul_valid_out = mp_v[LATENCY-1] | force_err;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          id;
        logic [15:0] prod;
        int          t;
    } op_t;

    bit          m_busy [NUM_REQ];
    bit          m_rv   [NUM_REQ];
    logic [15:0] m_rd   [NUM_REQ];
    int          m_rr;
    bit          m_err;
    int          cyc;
    op_t         inflight [$];

    always @(negedge clock) begin : compare
        int                    g;
        int                    k;
        bit                    wb;
        bit                    all_free;
        op_t                   op;
        logic [NUM_REQ-1:0]    e_ready;
        logic [NUM_REQ-1:0]    e_rv;
        logic [NUM_REQ*16-1:0] e_rd;
        logic [15:0]           e_in0;
        logic [15:0]           e_in1;
        int unsigned           p;
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                m_busy[i] = 0;
                m_rv[i]   = 0;
                m_rd[i]   = '0;
            end
            m_rr  = NUM_REQ - 1;
            m_err = 0;
            cyc   = 0;
            inflight.delete();
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_idle", idle, 1);
            chk("rst_error", error, 0);
        end else begin
            g = -1;
            for (int off = 1; off <= NUM_REQ; off++) begin
                k = (m_rr + off) % NUM_REQ;
                if (g < 0 && req_valid[k] && !m_busy[k]) g = k;
            end
            e_ready  = '0;
            e_in0    = '0;
            e_in1    = '0;
            all_free = 1;
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                e_in0      = req_in0[16*g +: 16];
                e_in1      = req_in1[16*g +: 16];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                e_rv[i]          = m_rv[i];
                e_rd[16*i +: 16] = m_rd[i];
                if (m_busy[i]) all_free = 0;
            end
            chk("req_ready", req_ready, e_ready);
            chk("mul_valid_in", mul_valid_in, (g >= 0) ? 1 : 0);
            chk("mul_in0", mul_in0, e_in0);
            chk("mul_in1", mul_in1, e_in1);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("rsp_data", rsp_data, e_rd);
            chk("idle", idle, (all_free && inflight.size() == 0) ? 1 : 0);
            chk("error", error, m_err);

            wb = (inflight.size() > 0) && (inflight[0].t + LATENCY == cyc);
            if (cyc >= LATENCY && mul_valid_out !== wb) m_err = 1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i]   = 0;
                    m_busy[i] = 0;
                end
            end
            if (wb) begin
                op = inflight.pop_front();
                m_rv[op.id] = 1;
                m_rd[op.id] = op.prod;
            end
            if (g >= 0) begin
                p = (32'(e_in0) * 32'(e_in1)) % 65536;
                m_busy[g] = 1;
                m_rr      = g;
                inflight.push_back('{g, p[15:0], cyc});
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]        = 1'b1;
        req_in0[16*i +: 16] = a;
        req_in1[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        force_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_in0   = '0;
        req_in1   = '0;
        rsp_ready = '0;
        force_err = 1'b0;
        tick();

        // Single op: 3*5, response three cycles after the grant.
        do_reset();
        set_req(0, 16'h0003, 16'h0005);
        #2;
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_mvi", mul_valid_in, 1);
        tick();
        req_valid = '0;
        tick();
        #2;
        chk("t1_not_yet", rsp_valid[0], 0);
        tick();
        rsp_ready[0] = 1'b1;
        #2;
        chk("t1_rspv", rsp_valid[0], 1);
        chk("t1_data", rsp_data[15:0], 16'h000F);
        tick();
        rsp_ready = '0;
        #2;
        chk("t1_rsp_clear", rsp_valid[0], 0);
        chk("t1_idle", idle, 1);
        tick();

        // Round robin with all results held.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(i + 2), 16'h0011);
        for (int c = 0; c < 8; c++) begin
            #2;
            chk("t2_grant", req_ready, (c < 4) ? (64'd1 << c) : 64'd0);
            if (c >= 3 && c <= 6) chk("t2_rsp_rise", rsp_valid, (64'd1 << (c - 2)) - 1);
            tick();
        end
        chk("t2_data3", rsp_data[63:48], 16'h0055);
        req_valid = '0;
        rsp_ready = '1;
        tick();
        rsp_ready = '0;
        tick();

        // Products that wrap to 16 bits.
        do_reset();
        set_req(2, 16'hFFFF, 16'h0002);
        tick();
        req_valid = '0;
        tick();
        tick();
        rsp_ready[2] = 1'b1;
        #2;
        chk("t3_wrap", rsp_data[47:32], 16'hFFFE);
        tick();
        rsp_ready = '0;
        set_req(2, 16'h1234, 16'h0100);
        tick();
        req_valid = '0;
        tick();
        tick();
        rsp_ready[2] = 1'b1;
        #2;
        chk("t3_shift", rsp_data[47:32], 16'h3400);
        tick();
        rsp_ready = '0;
        tick();

        // Busy blocks reissue until the cycle after the response handshake.
        do_reset();
        set_req(1, 16'h0007, 16'h0009);
        #2;
        chk("t4_first", req_ready, 4'b0010);
        tick();
        for (int c = 1; c <= 10; c++) begin
            #2;
            chk("t4_blocked", req_ready[1], 0);
            tick();
        end
        rsp_ready[1] = 1'b1;
        #2;
        chk("t4_hs_valid", rsp_valid[1], 1);
        chk("t4_same_cycle", req_ready[1], 0);
        tick();
        rsp_ready = '0;
        #2;
        chk("t4_next_cycle", req_ready[1], 1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        rsp_ready = '1;
        tick();
        rsp_ready = '0;
        tick();

        // Reset with a product in flight.
        do_reset();
        set_req(3, 16'h0100, 16'h0003);
        #2;
        chk("t5_grant", req_ready, 4'b1000);
        tick();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #2;
            chk("t5_no_rsp", rsp_valid, 0);
            chk("t5_no_err", error, 0);
            tick();
        end

        // Spurious multiplier valid outside the post-reset mask.
        do_reset();
        repeat (LATENCY + 2) tick();
        #2;
        chk("t6_pre", error, 0);
        force_err = 1'b1;
        tick();
        force_err = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("t6_sticky", error, 1);
            tick();
        end
        do_reset();
        #2;
        chk("t6_cleared", error, 0);
        tick();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid = NUM_REQ'($urandom);
            rsp_ready = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_in0[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                req_in1[16*i +: 16] = 16'($urandom);
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (LATENCY + 3) tick();
        #2;
        chk("final_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
